// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface dmem_arbiter_if;
  logic        req;
  logic        lock;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for the big-endian dataMem, with short locked bursts.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned or out-of-range accesses on both masters.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MAX_LOCK  = 4
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable,
  output logic        mem_MemRead,
  input  logic [31:0] mem_data
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [31:0]     addr_q;
  logic            rvalid0_q, rvalid1_q;
  logic [31:0]     rdata0_q, rdata1_q;
  logic            rerr0_q, rerr1_q;

  logic        gnt0, gnt1, any_gnt, owner_hit;
  logic        sel_we, sel_lock, bad;
  logic [31:0] sel_addr, sel_wdata;

  // last_q names the previous winner (1 = m1), so the other master takes a tie.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_hit = 1'b0;
    if (!reset) begin
      if (state_q == StOwn0 && m0.req) begin
        gnt0      = 1'b1;
        owner_hit = 1'b1;
      end else if (state_q == StOwn1 && m1.req) begin
        gnt1      = 1'b1;
        owner_hit = 1'b1;
      end else if (m0.req && m1.req) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? m1.we    : m0.we;
  assign sel_lock  = gnt1 ? m1.lock  : m0.lock;
  assign sel_addr  = gnt1 ? m1.addr  : m0.addr;
  assign sel_wdata = gnt1 ? m1.wdata : m0.wdata;

  assign bad = AlignCheck && any_gnt &&
               ((sel_addr[1:0] != 2'b00) || (sel_addr > 32'(MEM_BYTES - 4)));

  assign mem_address     = any_gnt ? sel_addr : addr_q;
  assign mem_writedata   = sel_wdata;
  assign mem_writeenable = any_gnt & sel_we & ~bad;
  assign mem_MemRead     = any_gnt & ~sel_we;

  // A released owner falls through to plain arbitration, so a new burst may start this cycle.
  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    last_d  = last_q;
    if (any_gnt) begin
      last_d = gnt1;
      if (owner_hit) begin
        if (sel_lock && (32'(cnt_q) < MAX_LOCK - 1)) begin
          state_d = state_q;
          cnt_d   = cnt_q + 1'b1;
        end
      end else if (sel_lock && (MAX_LOCK > 1)) begin
        state_d = gnt1 ? StOwn1 : StOwn0;
        cnt_d   = CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rerr0_q   <= 1'b0;
      rerr1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 & ~sel_we;
      rvalid1_q <= gnt1 & ~sel_we;
      rerr0_q   <= gnt0 & ~sel_we & bad;
      rerr1_q   <= gnt1 & ~sel_we & bad;
      if (any_gnt) addr_q <= sel_addr;
      if (gnt0 && !sel_we) rdata0_q <= bad ? 32'hDEADBEEF : mem_data;
      if (gnt1 && !sel_we) rdata1_q <= bad ? 32'hDEADBEEF : mem_data;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  // Write errors pulse with the grant; read errors ride along with rvalid.
  assign m0.err    = AlignCheck ? ((gnt0 & sel_we & bad) | rerr0_q) : 1'b0;
  assign m1.err    = AlignCheck ? ((gnt1 & sel_we & bad) | rerr1_q) : 1'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, per-cycle reference model, directed scenarios.
module tb_dmem_arbiter;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned MAX_LOCK  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  logic [31:0] mem_address, mem_writedata, mem_data;
  logic        mem_writeenable, mem_MemRead;

  dmem_arbiter #(
    .MEM_BYTES (MEM_BYTES),
    .MAX_LOCK  (MAX_LOCK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0              (m0_if),
    .m1              (m1_if),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_writeenable (mem_writeenable),
    .mem_MemRead     (mem_MemRead),
    .mem_data        (mem_data)
  );

  // Big-endian byte memory standing in for dataMem
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
  logic [9:0] i0, i1, i2, i3;
  assign i0 = mem_address[9:0];
  assign i1 = i0 + 10'd1;
  assign i2 = i0 + 10'd2;
  assign i3 = i0 + 10'd3;
  assign mem_data = {mem[i0], mem[i1], mem[i2], mem[i3]};
  always @(posedge clk) begin
    if (mem_writeenable) begin
      mem[i0] <= mem_writedata[31:24];
      mem[i1] <= mem_writedata[23:16];
      mem[i2] <= mem_writedata[15:8];
      mem[i3] <= mem_writedata[7:0];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: owner/beats describe a burst in progress, last is the previous winner.
  logic [7:0]  smem [MEM_BYTES] = '{default: 8'h00};
  bit          armed = 1'b0;
  int          owner = -1;
  int          beats = 0;
  int          last = 1;
  int          w, nb;
  logic        mbad;
  logic [31:0] haddr = '0;
  logic        pend [2] = '{1'b0, 1'b0};
  logic        perr [2] = '{1'b0, 1'b0};
  logic [31:0] prd  [2] = '{32'h0, 32'h0};
  logic        rq [2], lk [2], wen [2];
  logic [31:0] ad [2], wd [2];
  logic        act_rv [2], act_er [2];
  logic [31:0] act_rd [2];
  logic [31:0] exp_addr;
  logic [9:0]  b;
  int          gq [$];

  always @(negedge clk) begin
    rq  = '{m0_if.req,   m1_if.req};
    lk  = '{m0_if.lock,  m1_if.lock};
    wen = '{m0_if.we,    m1_if.we};
    ad  = '{m0_if.addr,  m1_if.addr};
    wd  = '{m0_if.wdata, m1_if.wdata};
    act_rv = '{m0_if.rvalid, m1_if.rvalid};
    act_rd = '{m0_if.rdata,  m1_if.rdata};
    act_er = '{m0_if.err,    m1_if.err};
    if (armed) begin
      w = -1;
      if (!reset) begin
        if (owner >= 0 && rq[owner]) w = owner;
        else if (rq[0] && rq[1]) w = (last == 0) ? 1 : 0;
        else if (rq[0]) w = 0;
        else if (rq[1]) w = 1;
        gq.push_back(m1_if.gnt ? 1 : (m0_if.gnt ? 0 : -1));
      end
      mbad = 1'b0;
      exp_addr = haddr;
      if (w >= 0) begin
        exp_addr = ad[w];
`ifdef DMEM_ALIGN_CHECK_EN
        mbad = (ad[w][1:0] != 2'b00) || (ad[w] > 32'(MEM_BYTES - 4));
`endif
      end
      chk("m0_gnt", 32'(m0_if.gnt), 32'(w == 0));
      chk("m1_gnt", 32'(m1_if.gnt), 32'(w == 1));
      chk("mem_we", 32'(mem_writeenable), 32'(w >= 0 && wen[w] && !mbad));
      chk("mem_rd", 32'(mem_MemRead), 32'(w >= 0 && !wen[w]));
      chk("mem_addr", mem_address, exp_addr);
      if (w >= 0 && wen[w]) chk("mem_wdata", mem_writedata, wd[w]);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_rvalid", k), 32'(act_rv[k]), 32'(pend[k]));
        chk($sformatf("m%0d_rdata", k), act_rd[k], prd[k]);
        chk($sformatf("m%0d_err", k), 32'(act_er[k]),
            32'(perr[k] || (w == k && wen[k] && mbad)));
      end
    end
    if (reset) begin
      armed = 1'b1;
      owner = -1;
      beats = 0;
      last  = 1;
      haddr = '0;
      pend  = '{1'b0, 1'b0};
      perr  = '{1'b0, 1'b0};
      prd   = '{32'h0, 32'h0};
    end else if (armed) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = (w == k) && !wen[k];
        perr[k] = pend[k] && mbad;
        if (pend[k]) begin
          b = ad[k][9:0];
          prd[k] = mbad ? 32'hDEADBEEF :
                   {smem[b], smem[b + 10'd1], smem[b + 10'd2], smem[b + 10'd3]};
        end
      end
      if (w >= 0) begin
        if (wen[w] && !mbad) begin
          b = ad[w][9:0];
          {smem[b], smem[b + 10'd1], smem[b + 10'd2], smem[b + 10'd3]} = wd[w];
        end
        nb = (owner == w) ? beats + 1 : 1;
        last = w;
        haddr = ad[w];
        if (lk[w] && nb < int'(MAX_LOCK)) begin
          owner = w;
          beats = nb;
        end else begin
          owner = -1;
          beats = 0;
        end
      end else begin
        owner = -1;
        beats = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    m0_if.req = 1'b0; m0_if.lock = 1'b0; m0_if.we = 1'b0;
    m1_if.req = 1'b0; m1_if.lock = 1'b0; m1_if.we = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int exp [], input int n);
    chk({name, "_len"}, 32'(gq.size()), 32'(n));
    for (int i = 0; i < n && i < gq.size(); i++)
      chk($sformatf("%s_%0d", name, i), 32'(gq[i]), 32'(exp[i]));
  endtask

  int t2_exp [] = '{0, 1, 0, 1};
  int t3_exp [] = '{1, 1, 1, 1, 0, 1, 1};

  initial begin
    drop_all();
    m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.addr = '0; m1_if.wdata = '0;
    cyc(2);
    @(negedge clk);
    chk("rst_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("rst_rdata", m1_if.rdata, 32'd0);
    chk("rst_we", 32'(mem_writeenable), 32'd0);
    cyc(1);
    reset = 1'b0;

    // T1: write then read back the same word
    m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h10; m0_if.wdata = 32'h11223344;
    @(negedge clk);
    chk("t1_wr_gnt", 32'(m0_if.gnt), 32'd1);
    chk("t1_wr_we", 32'(mem_writeenable), 32'd1);
    cyc(1);
    m0_if.we = 1'b0;
    @(negedge clk);
    chk("t1_rd_gnt", 32'(m0_if.gnt), 32'd1);
    chk("t1_rd_memread", 32'(mem_MemRead), 32'd1);
    cyc(1);
    m0_if.req = 1'b0;
    @(negedge clk);
    chk("t1_rvalid", 32'(m0_if.rvalid), 32'd1);
    chk("t1_rdata", m0_if.rdata, 32'h11223344);
    chk("t1_addr_hold", mem_address, 32'h10);
    cyc(1);

    // T2: both masters read every cycle straight out of reset
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    m0_if.req = 1'b1; m0_if.addr = 32'h10;
    m1_if.req = 1'b1; m1_if.addr = 32'h20;
    gq.delete();
    cyc(4);
    chk_seq("t2_gnt", t2_exp, 4);
    chk("t2_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    chk("t2_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("t2_m0_rdata", m0_if.rdata, 32'h11223344);

    // T3: m1 locked burst of 6 against a persistent m0
    m1_if.req = 1'b0;
    cyc(1);
    m1_if.req = 1'b1; m1_if.lock = 1'b1;
    gq.delete();
    cyc(7);
    chk_seq("t3_gnt", t3_exp, 7);
    m1_if.req = 1'b0; m1_if.lock = 1'b0;
    @(negedge clk);
    chk("t3_release_gnt", 32'(m0_if.gnt), 32'd1);
    cyc(1);
    m0_if.req = 1'b0;
    cyc(1);

    // T4: owner m0 drops req, m1 takes the same cycle and locks
    m0_if.req = 1'b1; m0_if.lock = 1'b1;
    cyc(1);
    m0_if.req = 1'b0; m0_if.lock = 1'b0;
    m1_if.req = 1'b1; m1_if.lock = 1'b1;
    @(negedge clk);
    chk("t4_m1_gnt", 32'(m1_if.gnt), 32'd1);
    chk("t4_m0_gnt", 32'(m0_if.gnt), 32'd0);
    cyc(1);
    m1_if.lock = 1'b0; m0_if.req = 1'b1;
    @(negedge clk);
    chk("t4_own1_gnt", 32'(m1_if.gnt), 32'd1);
    cyc(1);
    m1_if.req = 1'b0;
    cyc(1);
    m0_if.req = 1'b0;
    cyc(1);

    // T5: reset lands while an m1 burst read is in flight
    m1_if.req = 1'b1; m1_if.lock = 1'b1; m1_if.addr = 32'h10;
    @(negedge clk);
    chk("t5_m1_gnt", 32'(m1_if.gnt), 32'd1);
    cyc(1);
    reset = 1'b1;
    m1_if.req = 1'b0; m1_if.lock = 1'b0;
    @(negedge clk);
    chk("t5_gnt_in_reset", 32'(m1_if.gnt), 32'd0);
    cyc(1);
    reset = 1'b0;
    chk("t5_rvalid_dropped", 32'(m1_if.rvalid), 32'd0);
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    @(negedge clk);
    chk("t5_tie_m0", 32'(m0_if.gnt), 32'd1);
    chk("t5_tie_m1", 32'(m1_if.gnt), 32'd0);
    cyc(1);
    drop_all();
    cyc(1);

`ifdef DMEM_ALIGN_CHECK_EN
    // T6: misaligned write is suppressed, misaligned read returns the poison word
    m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h3FE; m0_if.wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_wr_err", 32'(m0_if.err), 32'd1);
    chk("t6_wr_we", 32'(mem_writeenable), 32'd0);
    cyc(1);
    m0_if.we = 1'b0; m0_if.addr = 32'h3FD;
    cyc(1);
    m0_if.req = 1'b0;
    chk("t6_rd_err", 32'(m0_if.err), 32'd1);
    chk("t6_rdata", m0_if.rdata, 32'hDEADBEEF);
    cyc(1);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
